cordic_vec: RTL and testbench

- Vectoring-mode CORDIC; the inverse of the existing rotation-mode cordic block.
- Takes a signed (x, y) pair, such as a cosine/sine pair, and returns its angle in the team's degrees×1e7 format, plus its gain-compensated magnitude.
- Iterative: one micro-rotation per clock. Uses the same start/done handshake as cordic, so the two blocks can be chained for round-trip checks.

---
 rtl/cordic_pkg.sv | 29 ++
 rtl/cordic_atan_lut.sv | 14 +
 rtl/cordic_vec.sv | 158 +++++++++++++++
 tb/tb_cordic_vec.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Constants shared by the rotation and vectoring CORDIC blocks.
// Angles are signed degrees x 1e7.
package cordic_pkg;

   localparam int unsigned ATAN_ENTRIES = 28;

   localparam logic signed [31:0] DEG_180      = 32'sd1_800_000_000;
   localparam logic        [31:0] CORDIC_INV_K = 32'h9B74EDA8;

   // atan(2^-i) in degrees x 1e7
   localparam logic [31:0] ATAN_LUT [0:ATAN_ENTRIES-1] = '{
      32'd450_000_000, 32'd265_650_512, 32'd140_362_435, 32'd71_250_163,
      32'd35_763_344,  32'd17_899_106,  32'd8_951_737,   32'd4_476_142,
      32'd2_238_105,   32'd1_119_057,   32'd559_529,     32'd279_765,
      32'd139_882,     32'd69_941,      32'd34_971,      32'd17_485,
      32'd8_743,       32'd4_371,       32'd2_186,       32'd1_093,
      32'd546,         32'd273,         32'd137,         32'd68,
      32'd34,          32'd17,          32'd9,           32'd4
   };

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE,
      ST_ITER,
      ST_SCALE,
      ST_DONE
   } cordic_state_e;

endpackage

// File: rtl/cordic_atan_lut.sv
// Combinational micro-rotation angle lookup, shared by both CORDIC modes.
module cordic_atan_lut
   import cordic_pkg::*;
(
   input  logic [4:0]  idx_i,
   output logic [31:0] atan_o
);

   always_comb begin
      atan_o = '0;
      if (idx_i < 5'(ATAN_ENTRIES)) atan_o = ATAN_LUT[idx_i];
   end

endmodule

// File: rtl/cordic_vec.sv
// Vectoring-mode CORDIC: (x, y) -> atan2 angle (degrees x 1e7) and
// gain-compensated magnitude, one micro-rotation per clock.
//
// state    | meaning
// IDLE     | waiting for start
// PRE      | quadrant pre-rotation / zero detect
// ITER     | micro-rotation i = 0 .. ITERATIONS-1
// SCALE    | 1/K scaling, angle wrap, load outputs
// DONE     | results held, done high, new start accepted
module cordic_vec
   import cordic_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int ANG_W      = 32,
   parameter int ITERATIONS = 24
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     s,
   input  logic signed [DATA_W-1:0] x_in,
   input  logic signed [DATA_W-1:0] y_in,
   output logic                     done,
   output logic signed [ANG_W-1:0]  angle,
   output logic signed [DATA_W-1:0] magnitude
);

   localparam int XW = DATA_W + 2;
   localparam int ZW = ANG_W + 2;
   localparam int PW = XW + 33;
   localparam logic signed [ZW-1:0] Z_180 = ZW'(DEG_180);
   localparam logic signed [ZW-1:0] Z_360 = Z_180 + Z_180;

   cordic_state_e          state_q, state_d;
   logic                   s_dly_q;
   logic signed [XW-1:0]   x_q, x_d, y_q, y_d;
   logic signed [ZW-1:0]   z_q, z_d;
   logic [4:0]             i_q, i_d;
   logic                   hold_z_q, hold_z_d;
   logic                   done_q, done_d;
   logic signed [ANG_W-1:0]  angle_q, angle_d;
   logic signed [DATA_W-1:0] mag_q, mag_d;

   logic                   start;
   logic [31:0]            atan;
   logic signed [ZW-1:0]   atan_z, z_out;
   logic signed [XW-1:0]   x_sh, y_sh;
   logic [PW-1:0]          prod;
   logic [DATA_W-1:0]      mag_sat;

   cordic_atan_lut u_lut (
      .idx_i  (i_q),
      .atan_o (atan)
   );

   assign start  = s & ~s_dly_q;
   assign atan_z = $signed({{(ZW-32){1'b0}}, atan});
   assign x_sh   = x_q >>> i_q;
   assign y_sh   = y_q >>> i_q;

   // x is never negative after pre-rotation; sign-extend anyway so the product stays exact
   assign prod = {{(PW-XW){x_q[XW-1]}}, x_q} * {{(PW-32){1'b0}}, CORDIC_INV_K};
   assign mag_sat = (|prod[PW-1:DATA_W+31]) ? {1'b0, {(DATA_W-1){1'b1}}}
                                            : prod[DATA_W+31:32];

   // keep the reported angle inside (-180, +180]
   always_comb begin
      z_out = z_q;
      if (z_q <= -Z_180)     z_out = z_q + Z_360;
      else if (z_q > Z_180)  z_out = Z_180;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         s_dly_q  <= 1'b0;
         x_q      <= '0;
         y_q      <= '0;
         z_q      <= '0;
         i_q      <= '0;
         hold_z_q <= 1'b0;
         done_q   <= 1'b0;
         angle_q  <= '0;
         mag_q    <= '0;
      end else begin
         state_q  <= state_d;
         s_dly_q  <= s;
         x_q      <= x_d;
         y_q      <= y_d;
         z_q      <= z_d;
         i_q      <= i_d;
         hold_z_q <= hold_z_d;
         done_q   <= done_d;
         angle_q  <= angle_d;
         mag_q    <= mag_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      z_d      = z_q;
      i_d      = i_q;
      hold_z_d = hold_z_q;
      done_d   = done_q;
      angle_d  = angle_q;
      mag_d    = mag_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               done_d  = 1'b0;
               x_d     = XW'(x_in);
               y_d     = XW'(y_in);
               state_d = ST_PRE;
            end
         end
         ST_PRE: begin
            i_d      = '0;
            z_d      = '0;
            // y on the real axis: angle is exactly 0 or 180, only x needs iterating
            hold_z_d = (y_q == '0);
            state_d  = ST_ITER;
            if (x_q == '0 && y_q == '0) begin
               state_d = ST_SCALE;
            end else if (x_q[XW-1]) begin
               x_d = -x_q;
               y_d = -y_q;
               z_d = y_q[XW-1] ? -Z_180 : Z_180;
            end
         end
         ST_ITER: begin
            if (!y_q[XW-1]) begin
               x_d = x_q + y_sh;
               y_d = y_q - x_sh;
               if (!hold_z_q) z_d = z_q + atan_z;
            end else begin
               x_d = x_q - y_sh;
               y_d = y_q + x_sh;
               if (!hold_z_q) z_d = z_q - atan_z;
            end
            i_d = i_q + 5'd1;
            if (i_q == 5'(ITERATIONS-1)) state_d = ST_SCALE;
         end
         ST_SCALE: begin
            angle_d = z_out[ANG_W-1:0];
            mag_d   = mag_sat;
            done_d  = 1'b1;
            state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign done      = done_q;
   assign angle     = angle_q;
   assign magnitude = mag_q;

endmodule

// File: tb/tb_cordic_vec.sv
// Scoreboard bench for cordic_vec: directed Q2.30 vectors, handshake corner
// cases and asynchronous reset, results checked by an independent monitor.
module tb_cordic_vec;

   localparam int DATA_W     = 32;
   localparam int ANG_W      = 32;
   localparam int ITERATIONS = 24;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic s   = 1'b0;
   logic signed [DATA_W-1:0] x_in = '0;
   logic signed [DATA_W-1:0] y_in = '0;
   logic                     done;
   logic signed [ANG_W-1:0]  angle;
   logic signed [DATA_W-1:0] magnitude;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      string  name;
      longint ang;
      longint ang_tol;
      longint mag;
      longint mag_tol;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   cordic_vec #(
      .DATA_W     (DATA_W),
      .ANG_W      (ANG_W),
      .ITERATIONS (ITERATIONS)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .s         (s),
      .x_in      (x_in),
      .y_in      (y_in),
      .done      (done),
      .angle     (angle),
      .magnitude (magnitude)
   );

   task automatic chk(input string name, input longint act, input longint exp, input longint tol);
      longint d;
      n_tests++;
      d = act - exp;
      if (d < 0) d = -d;
      if (d > tol) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, exp, tol);
      end
   endtask

   function automatic void push_exp(input string name, input longint ang, input longint atol,
                                    input longint mag, input longint mtol);
      exp_t e;
      e.name    = name;
      e.ang     = ang;
      e.ang_tol = atol;
      e.mag     = mag;
      e.mag_tol = mtol;
      sb.push_back(e);
   endfunction

   // monitor: every rising edge of done must match the oldest expectation
   logic done_prev = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (done && !done_prev) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_done: got result angle %0d, expected no result", angle);
         end else begin
            e = sb.pop_front();
            chk({e.name, "_angle"}, longint'(angle), e.ang, e.ang_tol);
            chk({e.name, "_mag"}, longint'(magnitude), e.mag, e.mag_tol);
         end
      end
      done_prev <= done;
   end

   task automatic wait_sb(input string name);
      int k;
      k = 0;
      while (sb.size() != 0 && k < 60) begin
         @(negedge clk);
         #1;
         k++;
      end
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL %s_timeout: %0d results outstanding, expected 0", name, sb.size());
         sb.delete();
      end
   endtask

   task automatic run_conv(input logic signed [31:0] xv, input logic signed [31:0] yv,
                           input string name, input longint ang, input longint atol,
                           input longint mag, input longint mtol);
      @(negedge clk);
      x_in = xv;
      y_in = yv;
      s    = 1'b1;
      push_exp(name, ang, atol, mag, mtol);
      @(negedge clk);
      s = 1'b0;
      wait_sb(name);
   endtask

   localparam longint ONE = 1_073_741_824;

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_done",  longint'(done),      0, 0);
      chk("rst_angle", longint'(angle),     0, 0);
      chk("rst_mag",   longint'(magnitude), 0, 0);
      rst = 1'b0;
      @(negedge clk);

      // 60 degrees, s held for 10 cycles, exact latency
      x_in = 536_870_912;
      y_in = 929_887_697;
      s    = 1'b1;
      push_exp("t60", 600_000_000, 300, ONE, 64);
      fork
         begin
            repeat (10) @(negedge clk);
            s = 1'b0;
         end
      join_none
      @(posedge clk);
      repeat (ITERATIONS + 1) @(posedge clk);
      #1 chk("lat_before", longint'(done), 0, 0);
      @(posedge clk);
      #1 chk("lat_after", longint'(done), 1, 0);
      wait_sb("t60");

      run_conv(-759_250_125,  759_250_125, "q2",  1_350_000_000, 300, ONE, 64);
      run_conv(-759_250_125, -759_250_125, "q3", -1_350_000_000, 300, ONE, 64);
      run_conv(0, -1_073_741_824,          "m90",  -900_000_000, 300, ONE, 64);
      run_conv(-1_073_741_824, 0,          "p180", 1_800_000_000,   0, ONE, 64);
      run_conv(0, 0,                       "zero", 0, 0, 0, 0);
      run_conv(32'sh8000_0000, 32'sh8000_0000, "minmin", -1_350_000_000, 300, 2_147_483_647, 0);

      // s held high for 100 cycles: exactly one conversion
      @(negedge clk);
      x_in = 929_887_697;
      y_in = 536_870_912;
      s    = 1'b1;
      push_exp("held", 300_000_000, 300, ONE, 64);
      repeat (100) @(negedge clk);
      chk("held_done", longint'(done), 1, 0);
      s = 1'b0;
      wait_sb("held");

      // second edge during ITER is ignored
      @(negedge clk);
      x_in = -759_250_125;
      y_in =  759_250_125;
      s    = 1'b1;
      push_exp("iter_ign", 1_350_000_000, 300, ONE, 64);
      @(negedge clk);
      s = 1'b0;
      repeat (4) @(negedge clk);
      x_in = 536_870_912;
      y_in = -929_887_697;
      s    = 1'b1;
      @(negedge clk);
      s = 1'b0;
      wait_sb("iter_ign");
      repeat (40) @(negedge clk);
      chk("iter_ign_done", longint'(done), 1, 0);

      // edge in DONE: done drops after the next edge, then new result
      @(negedge clk);
      chk("restart_pre_done", longint'(done), 1, 0);
      x_in = 0;
      y_in = 1_073_741_824;
      s    = 1'b1;
      push_exp("restart", 900_000_000, 300, ONE, 64);
      @(posedge clk);
      #1 chk("restart_drop", longint'(done), 0, 0);
      @(negedge clk);
      s = 1'b0;
      wait_sb("restart");

      // asynchronous reset in the middle of ITER
      @(negedge clk);
      x_in = 536_870_912;
      y_in = 929_887_697;
      s    = 1'b1;
      @(negedge clk);
      s = 1'b0;
      repeat (5) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_done",  longint'(done),      0, 0);
      chk("midrst_angle", longint'(angle),     0, 0);
      chk("midrst_mag",   longint'(magnitude), 0, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (30) @(negedge clk);
      chk("midrst_idle_done", longint'(done), 0, 0);
      run_conv(536_870_912, 929_887_697, "post_rst", 600_000_000, 300, ONE, 64);

      // round trip from rotation-block style cos/sin pairs
      run_conv(1_037_154_959, 277_904_834,   "rt15", 150_000_000, 500, ONE, 64);
      run_conv(929_887_697,   536_870_912,   "rt30", 300_000_000, 500, ONE, 64);
      run_conv(759_250_125,   759_250_125,   "rt45", 450_000_000, 500, ONE, 64);
      run_conv(277_904_834,   1_037_154_959, "rt75", 750_000_000, 500, ONE, 64);
      run_conv(0,             1_073_741_824, "rt90", 900_000_000, 500, ONE, 64);

      repeat (5) @(negedge clk);
      chk("sb_empty", longint'(sb.size()), 0, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500_000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule
